// File: rtl/regfile_pkg.sv
// Shared constants and types for the general-purpose register file.
package regfile_pkg;

   localparam int unsigned REG_WIDTH  = 64;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_ZERO   = 31;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_WIDTH-1:0]  reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux plus zero-register, write-through
// bypass and pending-reservation (busy) logic.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = REG_WIDTH,
   parameter int unsigned ADDR_W   = REG_ADDR_W,
   parameter int unsigned ZERO_REG = REG_ZERO
) (
   input  logic                                rst_i,
   input  logic [ADDR_W-1:0]                   addr_i,
   input  logic [(2**ADDR_W)-1:0][WIDTH-1:0]   regs_i,
   input  logic [(2**ADDR_W)-1:0]              pend_i,
   input  logic                                we_i,
   input  logic [ADDR_W-1:0]                   waddr_i,
   input  logic [WIDTH-1:0]                    wdata_i,
   output logic [WIDTH-1:0]                    data_o,
   output logic                                busy_o
);

   logic hit;

   // Select stored value or bypassed write data; zero register and reset force 0.
   always_comb begin
      data_o = '0;
      busy_o = 1'b0;
      hit    = we_i && (waddr_i == addr_i);
      if (!rst_i && (addr_i != ADDR_W'(ZERO_REG))) begin
         data_o = hit ? wdata_i : regs_i[addr_i];
         busy_o = pend_i[addr_i] && !hit;
      end
   end

endmodule : regfile_read_port

// File: rtl/regfile_bypass.sv
// Parametrised register file with N read ports, same-cycle write bypass and a
// per-register pending-write scoreboard for multi-cycle producers.
module regfile_bypass
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = REG_WIDTH,
   parameter int unsigned ADDR_W   = REG_ADDR_W,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned ZERO_REG = REG_ZERO
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NREAD-1:0][ADDR_W-1:0]  ReadRegister,
   output logic [NREAD-1:0][WIDTH-1:0]   ReadData,
   output logic [NREAD-1:0]              ReadBusy,
   input  logic [ADDR_W-1:0]             WriteRegister,
   input  logic [WIDTH-1:0]              WriteData,
   input  logic                          RegWrite,
   input  logic                          Reserve,
   input  logic [ADDR_W-1:0]             ReserveRegister
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
   logic [DEPTH-1:0]            pend_q, pend_d;

   // Next storage contents: writes to the zero register are dropped.
   always_comb begin
      regs_d = regs_q;
      if (RegWrite && (WriteRegister != ADDR_W'(ZERO_REG)))
         regs_d[WriteRegister] = WriteData;
   end

   // Next scoreboard: the write clears first so a same-register reservation wins.
   always_comb begin
      pend_d = pend_q;
      if (RegWrite)
         pend_d[WriteRegister] = 1'b0;
      if (Reserve && (ReserveRegister != ADDR_W'(ZERO_REG)))
         pend_d[ReserveRegister] = 1'b1;
   end

   // Storage and scoreboard state with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '0;
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   genvar k;
   generate
      for (k = 0; k < NREAD; k++) begin : g_rd
         regfile_read_port #(
            .WIDTH    (WIDTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
         ) u_port (
            .rst_i   (reset),
            .addr_i  (ReadRegister[k]),
            .regs_i  (regs_q),
            .pend_i  (pend_q),
            .we_i    (RegWrite),
            .waddr_i (WriteRegister),
            .wdata_i (WriteData),
            .data_o  (ReadData[k]),
            .busy_o  (ReadBusy[k])
         );
      end
   endgenerate

endmodule : regfile_bypass

// File: tb/tb_regfile_bypass.sv
// Directed and randomized checks of regfile_bypass against a behavioural model.
module tb_regfile_bypass;
   import regfile_pkg::*;

   localparam int unsigned NR = 4;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NR-1:0][4:0]       raddr;
   logic [NR-1:0][63:0]      rdata;
   logic [NR-1:0]            rbusy;
   logic [4:0]               waddr;
   logic [63:0]              wdata;
   logic                     we;
   logic                     res;
   logic [4:0]               resaddr;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [63:0] m_mem [32];
   bit          m_pend [32];

   regfile_bypass #(
      .WIDTH    (64),
      .ADDR_W   (5),
      .NREAD    (NR),
      .ZERO_REG (31)
   ) dut (
      .clk             (clk),
      .reset           (rst),
      .ReadRegister    (raddr),
      .ReadData        (rdata),
      .ReadBusy        (rbusy),
      .WriteRegister   (waddr),
      .WriteData       (wdata),
      .RegWrite        (we),
      .Reserve         (res),
      .ReserveRegister (resaddr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // compare every port against the model's view of the current inputs
   task automatic check_model();
      logic [63:0] ed;
      logic        eb;
      for (int k = 0; k < NR; k++) begin
         int a;
         a = int'(raddr[k]);
         ed = '0;
         eb = 1'b0;
         if (!rst && a != 31) begin
            if (we && int'(waddr) == a) ed = wdata;
            else                       ed = m_mem[a];
            eb = m_pend[a] && !(we && int'(waddr) == a);
         end
         chk($sformatf("data[%0d]@x%0d", k, a), rdata[k], ed);
         chk($sformatf("busy[%0d]@x%0d", k, a), {63'd0, rbusy[k]}, {63'd0, eb});
      end
   endtask

   task automatic drive(input logic r, input logic w, input int wa, input logic [63:0] wd,
                        input logic rv, input int ra,
                        input int a0, input int a1, input int a2, input int a3);
      rst = r; we = w; waddr = 5'(wa); wdata = wd; res = rv; resaddr = 5'(ra);
      raddr[0] = 5'(a0); raddr[1] = 5'(a1); raddr[2] = 5'(a2); raddr[3] = 5'(a3);
      #1;
      check_model();
   endtask

   // clock edge; model applies the architectural rules
   task automatic advance();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (we && waddr != 5'd31) m_mem[waddr] = wdata;
         if (we) m_pend[waddr] = 1'b0;
         if (res && resaddr != 5'd31) m_pend[resaddr] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int a0, input int a1, input int a2, input int a3);
      drive(0, 0, 0, '0, 0, 0, a0, a1, a2, a3);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_mem[i] = '0;
         m_pend[i] = 1'b0;
      end

      // 1: reset with a write to X5 that must be ignored
      drive(1, 1, 5, 64'h1234, 1, 6, 5, 5, 6, 0);
      chk("rst_data5", rdata[0], 64'h0);
      advance();
      for (int b = 0; b < 32; b += 4) begin
         idle(b, b + 1, b + 2, b + 3);
         advance();
      end
      idle(5, 5, 5, 5);
      chk("x5_after_rst", rdata[0], 64'h0);
      advance();

      // 2: bypass on X3, writes to X31 dropped
      drive(0, 1, 3, 64'hDEADBEEF_0000_0001, 0, 0, 3, 0, 0, 0);
      chk("x3_bypass", rdata[0], 64'hDEADBEEF_0000_0001);
      advance();
      idle(3, 3, 3, 3);
      chk("x3_stored", rdata[0], 64'hDEADBEEF_0000_0001);
      advance();
      drive(0, 1, 31, '1, 0, 0, 31, 31, 31, 31);
      chk("x31_bypass_zero", rdata[1], 64'h0);
      advance();
      idle(31, 31, 31, 31);
      chk("x31_zero", rdata[3], 64'h0);
      advance();

      // 3: load X1..X30 with index*0x0101, read four ports at once
      for (int i = 1; i <= 30; i++) begin
         drive(0, 1, i, 64'(i * 32'h0101), 0, 0, i, 0, 31, 30 - i);
         advance();
      end
      idle(1, 7, 7, 30);
      chk("p0_x1",  rdata[0], 64'h0101);
      chk("p1_x7",  rdata[1], 64'h0707);
      chk("p2_x7",  rdata[2], 64'h0707);
      chk("p3_x30", rdata[3], 64'h1E1E);
      advance();

      // 4: reservation on X9 cleared by the completing write
      drive(0, 0, 0, '0, 1, 9, 9, 9, 0, 0);
      advance();
      for (int i = 0; i < 3; i++) begin
         idle(9, 1, 2, 9);
         chk("x9_busy", {63'd0, rbusy[0]}, 64'd1);
         advance();
      end
      drive(0, 1, 9, 64'h42, 0, 0, 9, 9, 9, 9);
      chk("x9_wr_busy", {63'd0, rbusy[0]}, 64'd0);
      chk("x9_wr_data", rdata[0], 64'h42);
      advance();
      idle(9, 9, 9, 9);
      chk("x9_after_busy", {63'd0, rbusy[2]}, 64'd0);
      advance();

      // 5: same-cycle write and reserve leaves the register pending
      drive(0, 1, 4, 64'h7, 1, 4, 4, 4, 4, 4);
      advance();
      idle(4, 4, 4, 4);
      chk("x4_data", rdata[0], 64'h7);
      chk("x4_busy", {63'd0, rbusy[0]}, 64'd1);
      advance();
      drive(0, 0, 0, '0, 1, 31, 31, 31, 31, 31);
      advance();
      idle(31, 31, 31, 31);
      chk("x31_busy", {63'd0, rbusy[1]}, 64'd0);
      advance();

      // 6: reset drops a reservation; later write behaves normally
      drive(0, 0, 0, '0, 1, 12, 12, 12, 12, 12);
      advance();
      drive(1, 0, 0, '0, 0, 0, 12, 12, 12, 12);
      advance();
      idle(12, 12, 12, 12);
      chk("x12_rst_busy", {63'd0, rbusy[0]}, 64'd0);
      chk("x12_rst_data", rdata[0], 64'h0);
      advance();
      drive(0, 1, 12, 64'h55, 0, 0, 12, 12, 12, 12);
      advance();
      idle(12, 12, 12, 12);
      chk("x12_data", rdata[0], 64'h55);
      chk("x12_busy", {63'd0, rbusy[0]}, 64'd0);
      advance();

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 39) == 0),
               ($urandom_range(0, 1) == 1), int'($urandom_range(0, 31)),
               {$urandom, $urandom},
               ($urandom_range(0, 2) == 0), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_regfile_bypass

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
Parametrised general-purpose register file and the successor to the fixed 32x64, two-read-port file. It adds:
- a configurable read-port count;
- synchronous reset of all registers;
- same-cycle write-through bypass;
- a per-register pending-write scoreboard, so that multi-cycle producers (e.g. loads) can reserve a destination.

It sits between decode and execute in the datapath.

Parameters:
WIDTH, 64, data width of each register
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
NREAD, 2, number of independent read ports (1..4)
ZERO_REG, 31, index of the hardwired-zero register (always reads 0, never written, never pending)

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all registers and pending bits
ReadRegister  input  NREAD x ADDR_W  read address per port
ReadData  output  NREAD x WIDTH  read data per port (combinational)
ReadBusy  output  NREAD  1 = addressed register has an outstanding reservation
WriteRegister  input  ADDR_W  write address
WriteData  input  WIDTH  write data
RegWrite  input  1  write enable
Reserve  input  1  reserve request (mark destination pending)
ReserveRegister  input  ADDR_W  register to reserve

Behaviour:
- Storage: DEPTH-1 writable registers of WIDTH bits plus ZERO_REG, which is constant 0.
- Write: at the rising edge with reset=0, RegWrite=1 and WriteRegister != ZERO_REG, the register takes WriteData. Writes to ZERO_REG are silently dropped.
- Read (per port k, combinational, zero latency):
  - ReadRegister[k]==ZERO_REG -> ReadData[k]=0.
  - Otherwise, if RegWrite=1 and WriteRegister==ReadRegister[k] -> ReadData[k]=WriteData (bypass; the new value is visible in the same cycle).
  - Otherwise -> the stored value.
  - All ports are independent; several ports may read the same address.
- Scoreboard: one pending bit per register.
  - Edge with Reserve=1, ReserveRegister != ZERO_REG -> pending[ReserveRegister] set.
  - Edge with RegWrite=1 -> pending[WriteRegister] cleared.
  - Same register written and reserved in one cycle -> pending ends SET (the reservation is newer than the completing write).
  - Different registers -> both actions take effect.
  - Reserving an already-pending register: it stays pending, with no count or nesting.
- ReadBusy[k] = pending[ReadRegister[k]] AND NOT (RegWrite AND WriteRegister==ReadRegister[k]). The bypassed write satisfies the read in the same cycle. ReadBusy is always 0 for ZERO_REG.
- Reset (synchronous):
  - An edge with reset=1 clears every register to 0 and every pending bit to 0.
  - RegWrite and Reserve in that cycle are ignored, including for bypass.
  - While reset=1, ReadData=0 and ReadBusy=0 on all ports.
  - Reset asserted mid-reservation drops the reservation; a later write to that register behaves as a normal write.
- No X propagation: all outputs are defined for every address value.

Decomposition:
- Shared package regfile_pkg holds:
  - constants REG_WIDTH=64, REG_ADDR_W=5, REG_ZERO=31;
  - typedefs reg_addr_t (logic [REG_ADDR_W-1:0]) and reg_data_t (logic [REG_WIDTH-1:0]).
- One natural sub-module, regfile_read_port: address decode/mux over the storage array, plus the zero, bypass and busy logic for a single port. It is instantiated NREAD times in a generate loop.
- Storage and the scoreboard stay in the top module.

Test Plan:
1. Reset then read all 32 addresses on both ports -> every ReadData=0, every ReadBusy=0; RegWrite=1 to X5 during the reset cycle -> X5 still 0 after reset.
2. Write 0xDEADBEEF_0000_0001 to X3 with ReadRegister0=3 in the same cycle -> ReadData0=0xDEADBEEF_0000_0001 that cycle (bypass) and on all later cycles; write 0xFFFF... to X31 -> X31 reads 0 on every port.
3. NREAD=4, load X1..X30 with value = index*0x0101 -> all four ports reading 1, 7, 7, 30 return 0x0101, 0x0707, 0x0707, 0x1E1E simultaneously.
4. Reserve X9, idle 3 cycles -> ReadBusy=1 when reading X9; write X9=0x42 -> ReadBusy=0 and ReadData=0x42 in the write cycle; ReadBusy=0 on later cycles.
5. Reserve X4 and write X4=0x7 in the same cycle -> next cycle X4 reads 0x7 with ReadBusy=1. Reserve X31 -> ReadBusy stays 0.
6. Reserve X12, then assert reset for one cycle -> X12 has ReadBusy=0 and ReadData=0. A subsequent write of 0x55 to X12 reads back 0x55 with ReadBusy=0.
